// File: rtl/mem_src_arb_pkg.sv
// Shared constants and small index helpers for the memory-source arbiter.
package mem_src_arb_pkg;

    localparam int SRC_SDRAM = 0;
    localparam int SRC_FLASH = 1;
    localparam int SRC_ROM   = 2;
    localparam int NUM_SRC   = 3;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_BUSY = 1'b1;

    typedef enum logic {
        ST_IDLE = ARB_IDLE,
        ST_BUSY = ARB_BUSY
    } arb_state_e;

    // (a + b) mod 3 for a, b in 0..2
    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            return 2'(sum - 3'd3);
        end else begin
            return sum[1:0];
        end
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [2:0] v);
        if (v[0]) begin
            return 2'd0;
        end else if (v[1]) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    // rot[k] = v[(sh + k) mod 3], so bit 0 is the round-robin head
    function automatic logic [2:0] rotate3(input logic [2:0] v, input logic [1:0] sh);
        case (sh)
            2'd0:    return v;
            2'd1:    return {v[0], v[2], v[1]};
            2'd2:    return {v[1], v[0], v[2]};
            default: return v;
        endcase
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_src_wait_ctr.sv
// Saturating per-source wait counter with a registered starve flag.
module mem_src_wait_ctr
    import mem_src_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    input  logic gnt_rise,
    output logic starve
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             starve_r;

    // Next count: clear on idle or fresh grant, count while waiting, saturate.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (!req || gnt_rise) begin
            cnt_nxt_s = '0;
        end else if (!gnt && (cnt_r < LIMIT_C)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and starve flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r    <= '0;
            starve_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            starve_r <= (cnt_nxt_s == LIMIT_C);
        end
    end

    assign starve = starve_r;

endmodule

// File: rtl/mem_src_arbiter.sv
// Round-robin arbiter sharing one output bus between sdram/flash/rom with starvation override.
// Optional toggle coverage enabled by defining MEM_SRC_ARB_COV_EN.
module mem_src_arbiter
    import mem_src_arb_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int HOLD_MAX     = 2,
    parameter int STARVE_LIMIT = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [DATA_W-1:0] data_sdram,
    input  logic [DATA_W-1:0] data_flash,
    input  logic [DATA_W-1:0] data_rom,
    output logic [2:0]        gnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    input  logic              out_ready,
    output logic [2:0]        starve,
    output logic [5:0]        coverage
);

    localparam int BEAT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(HOLD_MAX - 1);

    arb_state_e        state_r, state_nxt_s;
    logic [2:0]        gnt_r, gnt_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic [DATA_W-1:0] out_data_r, out_data_nxt_s;
    logic [1:0]        out_src_r, out_src_nxt_s;
    logic [1:0]        rr_ptr_r, rr_ptr_nxt_s;
    logic [BEAT_W-1:0] beat_cnt_r, beat_cnt_nxt_s;

    logic [2:0]        starve_s;
    logic [2:0]        starve_hit_s;
    logic [1:0]        win_idx_s;
    logic [DATA_W-1:0] win_data_s;
    logic [DATA_W-1:0] cur_data_s;
    logic              cur_req_s;

    // Starving requesters win outright; otherwise search from the round-robin pointer.
    always_comb begin
        starve_hit_s = starve_s & req;
        if (|starve_hit_s) begin
            win_idx_s = lowest_idx(starve_hit_s);
        end else begin
            win_idx_s = add_mod3(rr_ptr_r, lowest_idx(rotate3(req, rr_ptr_r)));
        end
        case (win_idx_s)
            2'd0:    win_data_s = data_sdram;
            2'd1:    win_data_s = data_flash;
            2'd2:    win_data_s = data_rom;
            default: win_data_s = '0;
        endcase
    end

    // gnt is one-hot while busy, so the granted source's req/data fall out of an AND-OR.
    assign cur_req_s  = |(req & gnt_r);
    assign cur_data_s = ({DATA_W{gnt_r[0]}} & data_sdram) |
                        ({DATA_W{gnt_r[1]}} & data_flash) |
                        ({DATA_W{gnt_r[2]}} & data_rom);

    // FSM next-state and registered-output next values.
    always_comb begin
        state_nxt_s     = state_r;
        gnt_nxt_s       = gnt_r;
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        out_src_nxt_s   = out_src_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        beat_cnt_nxt_s  = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt_s     = ST_BUSY;
                    gnt_nxt_s       = onehot3(win_idx_s);
                    out_valid_nxt_s = 1'b1;
                    out_src_nxt_s   = win_idx_s;
                    out_data_nxt_s  = win_data_s;
                    beat_cnt_nxt_s  = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (out_valid_r && out_ready) begin
                    if (cur_req_s && (beat_cnt_r < BEAT_LAST)) begin
                        out_data_nxt_s = cur_data_s;
                        beat_cnt_nxt_s = beat_cnt_r + BEAT_W'(1);
                    end else begin
                        state_nxt_s     = ST_IDLE;
                        gnt_nxt_s       = 3'b000;
                        out_valid_nxt_s = 1'b0;
                        rr_ptr_nxt_s    = add_mod3(out_src_r, 2'd1);
                    end
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                gnt_nxt_s       = 3'b000;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 3'b000;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= 2'd0;
            rr_ptr_r    <= 2'd0;
            beat_cnt_r  <= '0;
        end else begin
            state_r     <= state_nxt_s;
            gnt_r       <= gnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_src_r   <= out_src_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            beat_cnt_r  <= beat_cnt_nxt_s;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_wait
        mem_src_wait_ctr #(
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_wait_ctr (
            .clock    (clock),
            .reset    (reset),
            .req      (req[i]),
            .gnt      (gnt_r[i]),
            .gnt_rise (gnt_nxt_s[i] & ~gnt_r[i]),
            .starve   (starve_s[i])
        );
    end

`ifdef MEM_SRC_ARB_COV_EN
    logic [2:0] gnt_prev_r;
    logic [2:0] starve_prev_r;
    logic [5:0] cov_r;

    // Sticky toggle bits: {gnt, starve} versus their previous-cycle values.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_prev_r    <= 3'b000;
            starve_prev_r <= 3'b000;
            cov_r         <= 6'h0;
        end else begin
            gnt_prev_r    <= gnt_r;
            starve_prev_r <= starve_s;
            cov_r         <= cov_r | {gnt_r ^ gnt_prev_r, starve_s ^ starve_prev_r};
        end
    end

    assign coverage = cov_r;
`else
    assign coverage = 6'h0;
`endif

    assign gnt       = gnt_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign starve    = starve_s;

endmodule

// File: tb/tb_mem_src_arbiter.sv
// Self-checking bench for mem_src_arbiter: vector table plus multi-cycle sequences, queue scoreboard.
module tb_mem_src_arbiter;

    logic       clock;
    logic       reset;
    logic [2:0] req;
    logic [3:0] data_sdram, data_flash, data_rom;
    logic [2:0] gnt;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_ready;
    logic [2:0] starve;
    logic [5:0] coverage;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0] gnt;
        logic       valid;
        logic [1:0] src;
        logic [3:0] data;
        logic [2:0] starve;
        string      name;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       rdy;
        logic [3:0] ds, df, dr;
        logic [2:0] eg;
        logic       ev;
        logic [1:0] es;
        logic [3:0] ed;
        logic [2:0] est;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    mem_src_arbiter #(
        .DATA_W       (4),
        .HOLD_MAX     (2),
        .STARVE_LIMIT (7)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .data_sdram (data_sdram),
        .data_flash (data_flash),
        .data_rom   (data_rom),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .starve     (starve),
        .coverage   (coverage)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: drive inputs, queue the expectation, clock, then compare.
    task automatic step(input logic rst, input logic [2:0] r, input logic rdy,
                        input logic [3:0] ds, input logic [3:0] df, input logic [3:0] dr,
                        input logic [2:0] eg, input logic ev, input logic [1:0] es,
                        input logic [3:0] ed, input logic [2:0] est, input string name);
        exp_t e;
        logic bad;
        reset      = rst;
        req        = r;
        out_ready  = rdy;
        data_sdram = ds;
        data_flash = df;
        data_rom   = dr;
        sb_q.push_back('{eg, ev, es, ed, est, name});
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        tests_run++;
        bad = (gnt !== e.gnt) || (out_valid !== e.valid) || (out_src !== e.src) ||
              (out_data !== e.data) || (starve !== e.starve);
`ifndef MEM_SRC_ARB_COV_EN
        bad = bad || (coverage !== 6'h0);
`endif
        if (bad) begin
            tests_failed++;
            $display("FAIL %s: got gnt=%b valid=%b src=%0d data=%h starve=%b cov=%b; expected gnt=%b valid=%b src=%0d data=%h starve=%b",
                     e.name, gnt, out_valid, out_src, out_data, starve, coverage,
                     e.gnt, e.valid, e.src, e.data, e.starve);
        end
    endtask

    initial begin
        int t2_last;
        reset = 1'b1; req = 3'b000; out_ready = 1'b0;
        data_sdram = 4'h0; data_flash = 4'h0; data_rom = 4'h0;

        // reset state, then idle with no requests
        tbl.push_back('{1'b1, 3'b000, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0, 2'd0, 4'h0, 3'b000});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 3'b000, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0, 2'd0, 4'h0, 3'b000});
        // all three requesting: two beats each with a bubble between grants
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b001, 1'b1, 2'd0, 4'h3, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b001, 1'b1, 2'd0, 4'h3, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b000, 1'b0, 2'd0, 4'h3, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b010, 1'b1, 2'd1, 4'h6, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b010, 1'b1, 2'd1, 4'h6, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b000, 1'b0, 2'd1, 4'h6, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b100, 1'b1, 2'd2, 4'h9, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b100, 1'b1, 2'd2, 4'h9, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b000, 1'b0, 2'd2, 4'h9, 3'b000});
        tbl.push_back('{1'b0, 3'b111, 1'b1, 4'h3, 4'h6, 4'h9, 3'b001, 1'b1, 2'd0, 4'h3, 3'b000});
        t2_last = tbl.size() - 1;
        // flash alone: second beat carries the updated data word
        tbl.push_back('{1'b1, 3'b000, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0, 2'd0, 4'h0, 3'b000});
        tbl.push_back('{1'b0, 3'b010, 1'b1, 4'h0, 4'hA, 4'h0, 3'b010, 1'b1, 2'd1, 4'hA, 3'b000});
        tbl.push_back('{1'b0, 3'b010, 1'b1, 4'h0, 4'h5, 4'h0, 3'b010, 1'b1, 2'd1, 4'h5, 3'b000});
        tbl.push_back('{1'b0, 3'b010, 1'b1, 4'h0, 4'h5, 4'h0, 3'b000, 1'b0, 2'd1, 4'h5, 3'b000});
        tbl.push_back('{1'b0, 3'b000, 1'b1, 4'h0, 4'h5, 4'h0, 3'b000, 1'b0, 2'd1, 4'h5, 3'b000});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].ds, tbl[i].df, tbl[i].dr,
                 tbl[i].eg, tbl[i].ev, tbl[i].es, tbl[i].ed, tbl[i].est, $sformatf("vec%0d", i));
`ifdef MEM_SRC_ARB_COV_EN
            if (i == t2_last) begin
                tests_run++;
                if (coverage !== 6'b111000) begin
                    tests_failed++;
                    $display("FAIL cov_rr: got %b expected %b", coverage, 6'b111000);
                end
            end
`endif
        end

        // sdram stalled: flash and rom starve, then starving sources win in index order
        step(1'b1, 3'b000, 1'b0, 4'h1, 4'h2, 4'h4, 3'b000, 1'b0, 2'd0, 4'h0, 3'b000, "stv_rst");
        for (int k = 1; k <= 10; k++)
            step(1'b0, 3'b111, 1'b0, 4'h1, 4'h2, 4'h4, 3'b001, 1'b1, 2'd0, 4'h1,
                 (k >= 7) ? 3'b110 : 3'b000, $sformatf("stv_wait%0d", k));
        step(1'b0, 3'b111, 1'b1, 4'h1, 4'h2, 4'h4, 3'b001, 1'b1, 2'd0, 4'h1, 3'b110, "stv_beat2");
        step(1'b0, 3'b111, 1'b1, 4'h1, 4'h2, 4'h4, 3'b000, 1'b0, 2'd0, 4'h1, 3'b110, "stv_rel");
        step(1'b0, 3'b111, 1'b1, 4'h1, 4'h2, 4'h4, 3'b010, 1'b1, 2'd1, 4'h2, 3'b100, "stv_flash");
        step(1'b0, 3'b111, 1'b1, 4'h1, 4'h2, 4'h4, 3'b010, 1'b1, 2'd1, 4'h2, 3'b100, "stv_flash2");
        step(1'b0, 3'b111, 1'b1, 4'h1, 4'h2, 4'h4, 3'b000, 1'b0, 2'd1, 4'h2, 3'b100, "stv_rel2");
        step(1'b0, 3'b111, 1'b1, 4'h1, 4'h2, 4'h4, 3'b100, 1'b1, 2'd2, 4'h4, 3'b000, "stv_rom");

        // reset while busy with a stalled beat
        step(1'b1, 3'b000, 1'b0, 4'h7, 4'h0, 4'h9, 3'b000, 1'b0, 2'd0, 4'h0, 3'b000, "mr_rst0");
        step(1'b0, 3'b001, 1'b0, 4'h7, 4'h0, 4'h9, 3'b001, 1'b1, 2'd0, 4'h7, 3'b000, "mr_gnt");
        step(1'b0, 3'b001, 1'b0, 4'h7, 4'h0, 4'h9, 3'b001, 1'b1, 2'd0, 4'h7, 3'b000, "mr_hold");
        step(1'b1, 3'b001, 1'b0, 4'h7, 4'h0, 4'h9, 3'b000, 1'b0, 2'd0, 4'h0, 3'b000, "mr_rst");
        step(1'b0, 3'b100, 1'b0, 4'h7, 4'h0, 4'h9, 3'b100, 1'b1, 2'd2, 4'h9, 3'b000, "mr_rom");

        // request dropped with a beat pending: the beat completes, then release
        step(1'b1, 3'b000, 1'b0, 4'h7, 4'h0, 4'h0, 3'b000, 1'b0, 2'd0, 4'h0, 3'b000, "drop_rst");
        step(1'b0, 3'b001, 1'b0, 4'h7, 4'h0, 4'h0, 3'b001, 1'b1, 2'd0, 4'h7, 3'b000, "drop_gnt");
        step(1'b0, 3'b000, 1'b0, 4'h7, 4'h0, 4'h0, 3'b001, 1'b1, 2'd0, 4'h7, 3'b000, "drop_hold");
        step(1'b0, 3'b000, 1'b1, 4'h7, 4'h0, 4'h0, 3'b000, 1'b0, 2'd0, 4'h7, 3'b000, "drop_rel");
        step(1'b0, 3'b000, 1'b1, 4'h7, 4'h0, 4'h0, 3'b000, 1'b0, 2'd0, 4'h7, 3'b000, "drop_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
